// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input code onto a small combinational gate,
// samples its output after SETTLE clocks per code, assembles the observed truth
// table and compares it against EXPECTED.
// Optional feature macro: GATE_SWEEP_ERRCNT_EN (adds err_cnt / first_err outputs).
module gate_sweep_checker #(
  parameter int            N        = 2,
  parameter int            SETTLE   = 1,
  parameter logic [2**N-1:0] EXPECTED = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              y,
  output logic [N-1:0]      in_vec,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   table_out,
  output logic              pass
`ifdef GATE_SWEEP_ERRCNT_EN
  ,
  output logic [N:0]        err_cnt,
  output logic [N-1:0]      first_err
`endif
);

  localparam int T  = 2**N;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [T-1:0]    table_nxt;

  // Table with the current sample folded in, so pass can be decided in the
  // same edge that writes the final entry.
  always_comb begin
    table_nxt         = table_out;
    table_nxt[in_vec] = y;
  end

  // Sweep sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      in_vec    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
`ifdef GATE_SWEEP_ERRCNT_EN
      err_cnt   <= '0;
      first_err <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_DRIVE;
            cnt       <= '0;
            in_vec    <= '0;
            table_out <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_cnt   <= '0;
            first_err <= '0;
`endif
          end
        end
        S_DRIVE: begin
          if (cnt == CW'(SETTLE - 1)) state <= S_SAMPLE;
          else                        cnt   <= cnt + CW'(1);
        end
        S_SAMPLE: begin
          table_out <= table_nxt;
`ifdef GATE_SWEEP_ERRCNT_EN
          if (y != EXPECTED[in_vec]) begin
            err_cnt <= err_cnt + (N+1)'(1);
            if (err_cnt == '0) first_err <= in_vec;
          end
`endif
          if (&in_vec) begin
            // Last code: stop here so in_vec never wraps.
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (table_nxt == EXPECTED);
          end else begin
            in_vec <= in_vec + N'(1);
            cnt    <= '0;
            state  <= S_DRIVE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (SETTLE=1 / EXPECTED=1111 and
// SETTLE=3 / EXPECTED=0110) share start/reset and a behavioural gate table.
module tb_gate_sweep_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] gtab = 4'hF;

  logic [1:0] iv [2];
  logic       bz [2];
  logic       dn [2];
  logic [3:0] tb_o [2];
  logic       ps [2];
  logic       yv [2];
`ifdef GATE_SWEEP_ERRCNT_EN
  logic [2:0] ec [2];
  logic [1:0] fe [2];
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_tab [2];
  int         per     [2];

  always #5 clk = ~clk;

  // Behavioural gate under test: combinational lookup from the driven code.
  assign yv[0] = gtab[iv[0]];
  assign yv[1] = gtab[iv[1]];

  gate_sweep_checker #(.N(2), .SETTLE(1), .EXPECTED(4'b1111)) u0 (
    .clk(clk), .reset(reset), .start(start), .y(yv[0]),
    .in_vec(iv[0]), .busy(bz[0]), .done(dn[0]), .table_out(tb_o[0]), .pass(ps[0])
`ifdef GATE_SWEEP_ERRCNT_EN
    , .err_cnt(ec[0]), .first_err(fe[0])
`endif
  );

  gate_sweep_checker #(.N(2), .SETTLE(3), .EXPECTED(4'b0110)) u1 (
    .clk(clk), .reset(reset), .start(start), .y(yv[1]),
    .in_vec(iv[1]), .busy(bz[1]), .done(dn[1]), .table_out(tb_o[1]), .pass(ps[1])
`ifdef GATE_SWEEP_ERRCNT_EN
    , .err_cnt(ec[1]), .first_err(fe[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk($sformatf("%s_d%0d_busy", tag, i), 32'(bz[i]), 0);
    chk($sformatf("%s_d%0d_done", tag, i), 32'(dn[i]), 0);
    chk($sformatf("%s_d%0d_invec", tag, i), 32'(iv[i]), 0);
    chk($sformatf("%s_d%0d_table", tag, i), 32'(tb_o[i]), 0);
    chk($sformatf("%s_d%0d_pass", tag, i), 32'(ps[i]), 0);
  endtask

  // Check instance i in cycle c after the start edge (cycle 1 = first DRIVE cycle).
  task automatic chk_inst(input int i, input int c);
    int d;
    int exp_iv;
    d      = 1 + 4 * per[i];
    exp_iv = (c < d) ? (c - 1) / per[i] : 3;
    chk($sformatf("d%0d_c%0d_busy", i, c), 32'(bz[i]), (c <= d) ? 1 : 0);
    chk($sformatf("d%0d_c%0d_done", i, c), 32'(dn[i]), (c == d) ? 1 : 0);
    chk($sformatf("d%0d_c%0d_invec", i, c), 32'(iv[i]), 32'(exp_iv));
    if (c == 1) chk($sformatf("d%0d_c1_table", i), 32'(tb_o[i]), 0);
    if (c < d) chk($sformatf("d%0d_c%0d_pass", i, c), 32'(ps[i]), 0);
    if (c >= d) begin
      chk($sformatf("d%0d_c%0d_table", i, c), 32'(tb_o[i]), 32'(gtab));
      chk($sformatf("d%0d_c%0d_pass", i, c), 32'(ps[i]), (gtab == exp_tab[i]) ? 1 : 0);
`ifdef GATE_SWEEP_ERRCNT_EN
      begin
        int n = 0;
        int f = -1;
        for (int k = 0; k < 4; k++)
          if (gtab[k] != exp_tab[i][k]) begin
            n++;
            if (f < 0) f = k;
          end
        if (f < 0) f = 0;
        chk($sformatf("d%0d_c%0d_errcnt", i, c), 32'(ec[i]), 32'(n));
        chk($sformatf("d%0d_c%0d_firsterr", i, c), 32'(fe[i]), 32'(f));
      end
`endif
    end
  endtask

  // One sweep of both instances. pre: start already high from the previous
  // cycle. repulse: start pulsed again mid-sweep. abort_at: cycle to assert
  // reset (0 = none). hold: start held high to test re-trigger on instance 0.
  task automatic sweep(input logic [3:0] tbl, input bit pre, input bit repulse,
                       input int abort_at, input bit hold);
    gtab = tbl;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk_idle(0, "abort");
        chk_idle(1, "abort");
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          chk($sformatf("abort_k%0d_done0", k), 32'(dn[0]), 0);
          chk($sformatf("abort_k%0d_done1", k), 32'(dn[1]), 0);
        end
        return;
      end
      if (hold && c == 2 + 1 + 4 * per[0]) begin
        // DONE at 9, IDLE at 10, re-accepted at the end of 10 -> new cycle 1 at 11.
        chk("hold_busy", 32'(bz[0]), 1);
        chk("hold_invec", 32'(iv[0]), 0);
        chk("hold_table", 32'(tb_o[0]), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      chk_inst(0, c);
      chk_inst(1, c);
      if (hold && c == 1 + 1 + 4 * per[0]) chk("hold_idle_busy", 32'(bz[0]), 0);
      if (repulse && c == 3) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    exp_tab[0] = 4'b1111;
    exp_tab[1] = 4'b0110;
    per[0] = 2;
    per[1] = 4;

    // Reset dominant over start for 3 cycles.
    reset = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle(0, $sformatf("rst%0d", k));
      chk_idle(1, $sformatf("rst%0d", k));
    end
    reset = 1'b0;
    sweep(4'b1111, 1'b1, 1'b0, 0, 1'b0);   // constant-1 cell, start held across release
    sweep(4'b0110, 1'b0, 1'b0, 0, 1'b0);   // XOR cell
    sweep(4'b1111, 1'b0, 1'b1, 0, 1'b0);   // restart attempt mid-sweep
    sweep(4'b1111, 1'b0, 1'b0, 5, 1'b0);   // reset at in_vec=2 on instance 0
    for (int r = 0; r < 6; r++)
      sweep(4'($urandom_range(0, 15)), 1'b0, 1'b0, 0, 1'b0);
    sweep(4'b1001, 1'b0, 1'b0, 0, 1'b1);   // start held: re-trigger after DONE
    sweep(4'b0110, 1'b0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
